// File: rtl/i2c_read_sched.sv
// i2c_read_sched: round-robin scheduler that shares one I2C read engine among four requesters.
//
// Ports:
//   pt_ck_i              clock (rising edge)
//   reset_n_i            asynchronous active-low reset
//   req_i[3:0]           level read requests, held until own rd_done_o bit
//   slv_addr_i[31:0]     packed slave addresses, requester i uses [8i+7:8i]
//   gnt_o[3:0]           one-hot grant, high from ARB exit through DONE
//   rd_done_o[3:0]       one-cycle completion pulse to the granted requester
//   rd_data_o[15:0]      captured read data, held until next capture
//   rd_ack_o             captured slave-address ACK
//   eng_go_o             start strobe to the engine, high GO_HOLD cycles
//   eng_slave_address_o  address presented to the engine
//   eng_end_ok_i         engine done/idle flag (low while busy)
//   eng_data16_i         engine read data
//   eng_ack_ok_i         engine address ACK status
//   busy_o               high whenever the scheduler is not idle
//   timeout_o            one-cycle pulse when a transaction is aborted
//
// Optional feature: define I2C_READ_SCHED_TIMEOUT_EN to abort a transaction that spends
// TIMEOUT_CYC cycles in WAIT_LO plus WAIT_HI. Without it the wait states never give up.
module i2c_read_sched #(
  parameter int unsigned GO_HOLD     = 4,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic        pt_ck_i,
  input  logic        reset_n_i,
  input  logic [3:0]  req_i,
  input  logic [31:0] slv_addr_i,
  output logic [3:0]  gnt_o,
  output logic [3:0]  rd_done_o,
  output logic [15:0] rd_data_o,
  output logic        rd_ack_o,
  output logic        eng_go_o,
  output logic [7:0]  eng_slave_address_o,
  input  logic        eng_end_ok_i,
  input  logic [15:0] eng_data16_i,
  input  logic        eng_ack_ok_i,
  output logic        busy_o,
  output logic        timeout_o
);

  typedef enum logic [2:0] {StIdle, StArb, StGoHi, StWaitLo, StWaitHi, StDone} state_e;

  state_e      state_q, state_d;
  logic [3:0]  gnt_q, gnt_d;
  logic [1:0]  gnt_idx_q, gnt_idx_d;
  logic [1:0]  last_q, last_d;
  logic [7:0]  addr_q, addr_d;
  logic [15:0] rd_data_q, rd_data_d;
  logic        rd_ack_q, rd_ack_d;
  logic [7:0]  go_cnt_q, go_cnt_d;
  logic        to_hit;

  // Round-robin search starting just after the last served index.
  logic       arb_hit;
  logic [1:0] arb_idx;
  logic [1:0] cand;
  always_comb begin
    arb_hit = 1'b0;
    arb_idx = last_q;
    cand    = last_q;
    for (int k = 1; k <= 4; k++) begin
      cand = last_q + k[1:0];
      if (!arb_hit && req_i[cand]) begin
        arb_hit = 1'b1;
        arb_idx = cand;
      end
    end
  end

`ifdef I2C_READ_SCHED_TIMEOUT_EN
  logic [15:0] to_cnt_q, to_cnt_d;

  assign to_hit = ((state_q == StWaitLo) || (state_q == StWaitHi)) &&
                  (to_cnt_q == 16'(TIMEOUT_CYC));

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (state_q == StGoHi) begin
      to_cnt_d = '0;
    end else if ((state_q == StWaitLo) || (state_q == StWaitHi)) begin
      if (to_cnt_q != 16'hFFFF) to_cnt_d = to_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge pt_ck_i or negedge reset_n_i) begin
    if (!reset_n_i) to_cnt_q <= '0;
    else            to_cnt_q <= to_cnt_d;
  end
`else
  assign to_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge pt_ck_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= StIdle;
    else            state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (|req_i) state_d = StArb;
      StArb:    state_d = arb_hit ? StGoHi : StIdle;
      StGoHi:   if (go_cnt_q == 8'(GO_HOLD - 1)) state_d = StWaitLo;
      StWaitLo: begin
        if (to_hit)             state_d = StIdle;
        else if (!eng_end_ok_i) state_d = StWaitHi;
      end
      StWaitHi: begin
        if (to_hit)            state_d = StIdle;
        else if (eng_end_ok_i) state_d = StDone;
      end
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Datapath next-state
  always_comb begin
    gnt_d     = gnt_q;
    gnt_idx_d = gnt_idx_q;
    last_d    = last_q;
    addr_d    = addr_q;
    rd_data_d = rd_data_q;
    rd_ack_d  = rd_ack_q;
    go_cnt_d  = go_cnt_q;
    if (state_q == StArb && arb_hit) begin
      gnt_d     = 4'b0001 << arb_idx;
      gnt_idx_d = arb_idx;
      addr_d    = slv_addr_i[{arb_idx, 3'b000} +: 8];
      go_cnt_d  = '0;
    end
    if (state_q == StGoHi) go_cnt_d = go_cnt_q + 8'd1;
    // Capture on the way into DONE so the data is valid alongside the pulse.
    if (state_q == StWaitHi && !to_hit && eng_end_ok_i) begin
      rd_data_d = eng_data16_i;
      rd_ack_d  = eng_ack_ok_i;
    end
    if (state_q == StDone) begin
      last_d = gnt_idx_q;
      gnt_d  = '0;
    end
    if (to_hit) begin
      last_d   = gnt_idx_q;
      gnt_d    = '0;
      rd_ack_d = 1'b0;
    end
  end

  always_ff @(posedge pt_ck_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      gnt_q     <= '0;
      gnt_idx_q <= '0;
      last_q    <= 2'd3;
      addr_q    <= '0;
      rd_data_q <= '0;
      rd_ack_q  <= 1'b0;
      go_cnt_q  <= '0;
    end else begin
      gnt_q     <= gnt_d;
      gnt_idx_q <= gnt_idx_d;
      last_q    <= last_d;
      addr_q    <= addr_d;
      rd_data_q <= rd_data_d;
      rd_ack_q  <= rd_ack_d;
      go_cnt_q  <= go_cnt_d;
    end
  end

  // Outputs
  always_comb begin
    gnt_o               = gnt_q;
    eng_go_o            = (state_q == StGoHi);
    busy_o              = (state_q != StIdle);
    timeout_o           = to_hit;
    rd_done_o           = ((state_q == StDone) || to_hit) ? gnt_q : 4'b0000;
    rd_data_o           = rd_data_q;
    rd_ack_o            = rd_ack_q & ~to_hit;
    eng_slave_address_o = addr_q;
  end

endmodule

// File: tb/tb_i2c_read_sched.sv
// Directed testbench for i2c_read_sched with a small behavioural read-engine model.
module tb_i2c_read_sched;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req;
  logic [31:0] slv_addr;
  logic [3:0]  gnt;
  logic [3:0]  rd_done;
  logic [15:0] rd_data;
  logic        rd_ack;
  logic        eng_go;
  logic [7:0]  eng_addr;
  logic        eng_end_ok;
  logic [15:0] eng_data16;
  logic        eng_ack_ok;
  logic        busy;
  logic        timeout;

  always #5 clk = ~clk;

  i2c_read_sched #(
    .GO_HOLD    (4),
    .TIMEOUT_CYC(100)
  ) dut (
    .pt_ck_i            (clk),
    .reset_n_i          (reset_n),
    .req_i              (req),
    .slv_addr_i         (slv_addr),
    .gnt_o              (gnt),
    .rd_done_o          (rd_done),
    .rd_data_o          (rd_data),
    .rd_ack_o           (rd_ack),
    .eng_go_o           (eng_go),
    .eng_slave_address_o(eng_addr),
    .eng_end_ok_i       (eng_end_ok),
    .eng_data16_i       (eng_data16),
    .eng_ack_ok_i       (eng_ack_ok),
    .busy_o             (busy),
    .timeout_o          (timeout)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Engine model: after ENG_GO falls, go busy for eng_busy_cyc cycles then report.
  int          eng_busy_cyc = 3;
  logic        eng_stall    = 1'b0;
  logic [15:0] rsp_data     = 16'h0000;
  logic        rsp_ack      = 1'b0;

  initial begin
    eng_end_ok = 1'b1;
    eng_data16 = 16'h0000;
    eng_ack_ok = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (eng_go && !eng_stall) begin
        while (eng_go) begin
          @(posedge clk);
          #2;
        end
        eng_end_ok = 1'b0;
        repeat (eng_busy_cyc) begin
          @(posedge clk);
          #2;
        end
        eng_data16 = rsp_data;
        eng_ack_ok = rsp_ack;
        eng_end_ok = 1'b1;
      end
    end
  end

  // Protocol monitors
  int viol       = 0;
  int done_count = 0;
  always @(negedge clk) begin
    if ($countones(gnt) > 1) viol++;
    if (eng_go && gnt == 4'b0000) viol++;
    if (rd_done != 4'b0000) done_count++;
  end

  task automatic do_reset();
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(1);
  endtask

  task automatic wait_done(input string tag, output logic [3:0] done);
    for (int i = 0; i < 200; i++) begin
      step();
      if (rd_done != 4'b0000) break;
    end
    check({tag, "_seen"}, 32'(rd_done != 4'b0000), 32'd1);
    done = rd_done;
  endtask

  task automatic wait_end_low(input string tag);
    for (int i = 0; i < 50; i++) begin
      if (!eng_end_ok) break;
      step();
    end
    check({tag, "_eng_busy"}, 32'(eng_end_ok), 32'd0);
  endtask

  logic [3:0] d;
  int         cnt;
  int         done_before;

  initial begin
    reset_n  = 1'b0;
    req      = 4'b0000;
    slv_addr = 32'h5A33_2248;
    #1;
    // Reset values while reset is held
    check("rst_gnt", gnt, 4'h0);
    check("rst_busy", busy, 0);
    check("rst_go", eng_go, 0);
    check("rst_done", rd_done, 4'h0);
    check("rst_data", rd_data, 16'h0);
    check("rst_addr", eng_addr, 8'h0);
    check("rst_timeout", timeout, 0);
    step(2);
    reset_n = 1'b1;
    step(1);

    // Single read, requester 0
    rsp_data = 16'hBEEF;
    rsp_ack  = 1'b1;
    req      = 4'b0001;
    step();
    check("t1_go_lat1", eng_go, 0);
    check("t1_busy", busy, 1);
    step();
    check("t1_go_lat2", eng_go, 1);
    check("t1_gnt", gnt, 4'b0001);
    check("t1_addr", eng_addr, 8'h48);
    cnt = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (eng_go) cnt++;
    end
    check("t1_go_len", cnt, 4);
    wait_done("t1", d);
    check("t1_done", d, 4'b0001);
    check("t1_done_gnt", gnt, 4'b0001);
    check("t1_data", rd_data, 16'hBEEF);
    check("t1_ack", rd_ack, 1);
    check("t1_to", timeout, 0);
    req = 4'b0000;
    step();
    check("t1_done_pulse", rd_done, 4'h0);
    check("t1_gnt_clr", gnt, 4'h0);
    check("t1_idle", busy, 0);
    check("t1_data_hold", rd_data, 16'hBEEF);

    // LAST=0, REQ=1001 -> 3 (NACK); then LAST=3 -> 0
    rsp_data = 16'h0000;
    rsp_ack  = 1'b0;
    req      = 4'b1001;
    wait_done("rr1", d);
    check("rr1_done", d, 4'b1000);
    check("rr1_addr", eng_addr, 8'h5A);
    check("nack_ack", rd_ack, 0);
    check("nack_data", rd_data, 16'h0000);
    check("nack_to", timeout, 0);
    rsp_data = 16'h1234;
    rsp_ack  = 1'b1;
    wait_done("rr2", d);
    check("rr2_done", d, 4'b0001);
    check("rr2_data", rd_data, 16'h1234);
    check("rr2_ack", rd_ack, 1);
    req = 4'b0000;
    step(3);

    // All requesting continuously: 0,1,2,3,0
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_done("rr4", d);
      check($sformatf("rr4_order%0d", k), d, 32'(4'b0001 << (k % 4)));
    end
    req = 4'b0000;
    step(3);

    // Requester 2 drops during WAIT_HI
    do_reset();
    req = 4'b0100;
    wait_end_low("drop");
    req = 4'b0000;
    wait_done("drop", d);
    check("drop_done", d, 4'b0100);
    step();
    check("drop_idle1", busy, 0);
    step();
    check("drop_idle2", busy, 0);

    // Engine never accepts
    do_reset();
    eng_stall = 1'b1;
    req = 4'b0001;
    for (int i = 0; i < 20; i++) begin
      if (eng_go) break;
      step();
    end
    for (int i = 0; i < 20; i++) begin
      if (!eng_go) break;
      step();
    end
    // Now in the first WAIT_LO cycle
`ifdef I2C_READ_SCHED_TIMEOUT_EN
    cnt = 0;
    for (int i = 0; i < 99; i++) begin
      step();
      if (timeout || rd_done != 4'h0) cnt++;
    end
    check("to_early", cnt, 0);
    step();
    check("to_pulse", timeout, 1);
    check("to_done", rd_done, 4'b0001);
    check("to_ack", rd_ack, 0);
    req = 4'b0000;
    step();
    check("to_pulse_end", timeout, 0);
    check("to_idle", busy, 0);
`else
    done_before = done_count;
    step(200);
    check("stall_busy", busy, 1);
    check("stall_to", timeout, 0);
    check("stall_no_done", done_count - done_before, 0);
`endif
    eng_stall = 1'b0;
    req = 4'b0000;
    do_reset();

    // Reset during WAIT_HI
    eng_busy_cyc = 10;
    req = 4'b0001;
    wait_end_low("rst");
    step(2);
    done_before = done_count;
    reset_n = 1'b0;
    #1;
    check("rst_mid_gnt", gnt, 4'h0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", rd_done, 4'h0);
    check("rst_mid_addr", eng_addr, 8'h0);
    check("rst_mid_go", eng_go, 0);
    step(3);
    reset_n = 1'b1;
    req = 4'b0000;
    step(15);
    check("rst_mid_nodone", done_count - done_before, 0);
    eng_busy_cyc = 3;
    req = 4'b0110;
    step(2);
    check("rst_first_gnt", gnt, 4'b0010);
    wait_done("rst_after", d);
    check("rst_after_done", d, 4'b0010);
    req = 4'b0000;
    step(3);

    check("gnt_onehot", viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/i2c_read_sched.md
I2C_READ_SCHED -- requirements
Module: i2c_read_sched

Interface
REQ-001 Parameter GO_HOLD, default 4: cycles ENG_GO is held high per transaction (legal range 1..255).
REQ-002 Parameter TIMEOUT_CYC, default 65535: maximum cycles in WAIT_LO plus WAIT_HI before abort (16-bit).
REQ-003 PT_CK  in  1  single clock; all logic on rising edge.
REQ-004 RESET_N  in  1  asynchronous, active-low reset.
REQ-005 REQ  in  4  per-requester read request; level, held until own RD_DONE bit.
REQ-006 SLV_ADDR  in  32  packed slave addresses; requester i uses bits [8i+7:8i].
REQ-007 GNT  out  4  one-hot grant; high from ARB exit through DONE.
REQ-008 RD_DONE  out  4  one-cycle pulse to the granted requester on completion.
REQ-009 RD_DATA  out  16  captured read data; valid with RD_DONE, held until next capture.
REQ-010 RD_ACK  out  1  captured slave-address ACK; valid with RD_DONE.
REQ-011 ENG_GO  out  1  start strobe to the I2C read engine.
REQ-012 ENG_SLAVE_ADDRESS  out  8  address to the engine; stable from GO_HI until IDLE.
REQ-013 ENG_END_OK  in  1  engine done/idle flag (low while busy).
REQ-014 ENG_DATA16  in  16  engine read data.
REQ-015 ENG_ACK_OK  in  1  engine address ACK status.
REQ-016 BUSY  out  1  high in every state except IDLE.
REQ-017 TIMEOUT  out  1  one-cycle pulse on transaction abort.

Function
REQ-018 FSM states: IDLE, ARB, GO_HI, WAIT_LO, WAIT_HI, DONE.
- IDLE: if any REQ bit high -> ARB next cycle.
- ARB: grant via round-robin starting at index (LAST+1) mod 4, load ENG_SLAVE_ADDRESS, -> GO_HI.
- GO_HI: ENG_GO=1 for GO_HOLD cycles, then ENG_GO=0, -> WAIT_LO.
- WAIT_LO: wait ENG_END_OK==0 (engine accepted) -> WAIT_HI.
- WAIT_HI: wait ENG_END_OK==1 -> DONE.
- DONE: capture ENG_DATA16/ENG_ACK_OK into RD_DATA/RD_ACK, pulse RD_DONE[g], update LAST=g, clear GNT, -> IDLE.
REQ-019 REQ-to-ENG_GO latency SHALL be exactly 2 cycles (IDLE sample, ARB, GO_HI).
REQ-020 At most one GNT bit high at any time; ENG_GO only high in GO_HI.
REQ-021 If REQ[g] drops mid-transaction, the transaction SHALL complete and RD_DONE[g] still pulse.
REQ-022 New REQ arrivals during a transaction SHALL not alter GNT; they are arbitrated in the next ARB.
REQ-023 Simultaneous REQ with LAST=3, REQ=4'b1001 -> grant index 0; LAST=0, REQ=4'b1001 -> grant index 3.
REQ-024 Back-to-back: a requester with REQ still high after RD_DONE SHALL re-arbitrate, never starving others (worst-case wait 3 transactions).
REQ-025 GO_HOLD cycle counter 8-bit, cleared on entry to GO_HI; timeout counter 16-bit, cleared on entry to WAIT_LO, saturating.

Reset
REQ-026 On RESET_N low, immediately: state=IDLE, GNT=0, RD_DONE=0, RD_DATA=0, RD_ACK=0, ENG_GO=0, ENG_SLAVE_ADDRESS=0, BUSY=0, TIMEOUT=0, LAST=3, counters=0.
REQ-027 Reset mid-transaction SHALL abort without RD_DONE; first grant after reset goes to lowest requesting index.

Configuration
REQ-028 Macro I2C_READ_SCHED_TIMEOUT_EN: when defined, counter reaching TIMEOUT_CYC in WAIT_LO/WAIT_HI SHALL pulse TIMEOUT and RD_DONE[g] with RD_ACK=0, RD_DATA unchanged, LAST=g, -> IDLE.
REQ-029 Without I2C_READ_SCHED_TIMEOUT_EN: no timeout counter, TIMEOUT tied 0, WAIT states wait indefinitely.

Verification
REQ-030 REQ=4'b0001, SLV_ADDR[7:0]=8'h48, engine model returns 16'hBEEF ACK=1 -> ENG_GO high 4 cycles starting 2 cycles after REQ, ENG_SLAVE_ADDRESS=8'h48, RD_DONE=4'b0001 with RD_DATA=16'hBEEF, RD_ACK=1.
REQ-031 REQ=4'b1111 held continuously -> grant order 0,1,2,3,0; exactly one GNT bit at a time.
REQ-032 REQ[2] dropped during WAIT_HI -> RD_DONE[2] still pulses, then IDLE if no other REQ.
REQ-033 With macro, TIMEOUT_CYC=100, engine never drops ENG_END_OK -> TIMEOUT and RD_DONE pulse 100 cycles after WAIT_LO entry, RD_ACK=0; without macro, BUSY stays high.
REQ-034 RESET_N asserted in WAIT_HI -> all outputs zero same cycle, no RD_DONE; after release REQ=4'b0110 -> GNT=4'b0010.
REQ-035 Engine NACK (ENG_ACK_OK=0, DATA16=16'h0000) -> RD_DONE with RD_ACK=0, RD_DATA=16'h0000, no TIMEOUT.
